alu_exec: RTL

Two-stage pipelined integer execution unit that sits directly downstream of the reservation station. It accepts one ready RV32I non-memory instruction per cycle (operands already resolved), computes the result plus branch/jump resolution, and broadcasts it on the ALU result bus. That bus is consumed by the reservation station, the load/store buffer and the ROB. The unit never stalls its producer.

---
 rtl/alu_exec_if.sv | 32 +++
 rtl/alu_exec.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if: issue and result bus between the reservation station and the ALU
// master: producer side (drives the issue fields, observes the result bus)
// slave:  ALU side (consumes the issue fields, drives the result bus)
//   work_en, rob_id_from_rs[3:0], opcode_from_rs[5:0]  issue strobe, tag, internal opcode
//   val1, val2, imm_from_rs, pc_from_rs [31:0]         resolved operands, immediate, PC
//   is_alu_ok, rob_id_from_alu[3:0], res_from_alu      result strobe, tag, rd value
//   is_jump_br, br_taken, br_target                    control-flow resolution
interface alu_exec_if;
    logic        work_en;
    logic [3:0]  rob_id_from_rs;
    logic [5:0]  opcode_from_rs;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] imm_from_rs;
    logic [31:0] pc_from_rs;
    logic        is_alu_ok;
    logic [3:0]  rob_id_from_alu;
    logic [31:0] res_from_alu;
    logic        is_jump_br;
    logic        br_taken;
    logic [31:0] br_target;

    modport master (
        output work_en, rob_id_from_rs, opcode_from_rs, val1, val2, imm_from_rs, pc_from_rs,
        input  is_alu_ok, rob_id_from_alu, res_from_alu, is_jump_br, br_taken, br_target
    );

    modport slave (
        input  work_en, rob_id_from_rs, opcode_from_rs, val1, val2, imm_from_rs, pc_from_rs,
        output is_alu_ok, rob_id_from_alu, res_from_alu, is_jump_br, br_taken, br_target
    );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: two-stage pipelined RV32I integer execution unit with branch resolution
// clk    rising-edge clock
// rst_n  asynchronous active-low reset
// rdy    global enable; all state holds while low
// clear  synchronous pipeline flush, wins over work_en
// bus    alu_exec_if.slave: issue fields in, result bus out
module alu_exec (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rdy,
    input  logic       clear,
    alu_exec_if.slave  bus
);
    localparam logic [5:0] OP_LUI   = 6'd0;
    localparam logic [5:0] OP_AUIPC = 6'd1;
    localparam logic [5:0] OP_JAL   = 6'd2;
    localparam logic [5:0] OP_JALR  = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BGE   = 6'd7;
    localparam logic [5:0] OP_BLTU  = 6'd8;
    localparam logic [5:0] OP_BGEU  = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SLTI  = 6'd11;
    localparam logic [5:0] OP_SLTIU = 6'd12;
    localparam logic [5:0] OP_XORI  = 6'd13;
    localparam logic [5:0] OP_ORI   = 6'd14;
    localparam logic [5:0] OP_ANDI  = 6'd15;
    localparam logic [5:0] OP_SLLI  = 6'd16;
    localparam logic [5:0] OP_SRLI  = 6'd17;
    localparam logic [5:0] OP_SRAI  = 6'd18;
    localparam logic [5:0] OP_ADD   = 6'd19;
    localparam logic [5:0] OP_SUB   = 6'd20;
    localparam logic [5:0] OP_SLL   = 6'd21;
    localparam logic [5:0] OP_SLT   = 6'd22;
    localparam logic [5:0] OP_SLTU  = 6'd23;
    localparam logic [5:0] OP_XOR   = 6'd24;
    localparam logic [5:0] OP_SRL   = 6'd25;
    localparam logic [5:0] OP_SRA   = 6'd26;
    localparam logic [5:0] OP_OR    = 6'd27;
    localparam logic [5:0] OP_AND   = 6'd28;

    logic        accept;
    logic        use_imm;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] tgt_in;

    logic        s1_valid;
    logic [3:0]  s1_tag;
    logic [5:0]  s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [31:0] s1_target;
    logic [31:0] s1_link;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic        eq;
    logic        lt;
    logic        ltu;
    logic        is_br;
    logic        is_jmp;
    logic        cond;
    logic        taken;
    logic [31:0] res;

    // Operand routing happens at issue so S2 only sees a uniform (a, b) pair.
    always_comb begin
        accept  = bus.work_en & ~clear;
        use_imm = (bus.opcode_from_rs == OP_LUI) || (bus.opcode_from_rs == OP_AUIPC) ||
                  (bus.opcode_from_rs >= OP_ADDI && bus.opcode_from_rs <= OP_SRAI);
        a_in    = (bus.opcode_from_rs == OP_LUI)   ? 32'd0 :
                  (bus.opcode_from_rs == OP_AUIPC) ? bus.pc_from_rs : bus.val1;
        b_in    = use_imm ? bus.imm_from_rs : bus.val2;
        tgt_in  = (bus.opcode_from_rs == OP_JALR) ? ((bus.val1 + bus.imm_from_rs) & ~32'd1) :
                  bus.pc_from_rs + bus.imm_from_rs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else if (rdy)
            s1_valid <= accept;
    end

    // Payload needs no reset: it is only consumed while s1_valid is set.
    always_ff @(posedge clk) begin
        if (rdy && accept) begin
            s1_tag    <= bus.rob_id_from_rs;
            s1_op     <= bus.opcode_from_rs;
            s1_a      <= a_in;
            s1_b      <= b_in;
            s1_target <= tgt_in;
            s1_link   <= bus.pc_from_rs + 32'd4;
        end
    end

    always_comb begin
        sum    = s1_a + s1_b;
        diff   = s1_a - s1_b;
        shamt  = s1_b[4:0];
        eq     = s1_a == s1_b;
        lt     = $signed(s1_a) < $signed(s1_b);
        ltu    = s1_a < s1_b;
        is_br  = s1_op >= OP_BEQ && s1_op <= OP_BGEU;
        is_jmp = s1_op == OP_JAL || s1_op == OP_JALR;
        cond   = (s1_op == OP_BEQ)  ? eq   :
                 (s1_op == OP_BNE)  ? ~eq  :
                 (s1_op == OP_BLT)  ? lt   :
                 (s1_op == OP_BGE)  ? ~lt  :
                 (s1_op == OP_BLTU) ? ltu  : ~ltu;
        taken  = is_jmp | (is_br & cond);
        case (s1_op)
            OP_LUI, OP_AUIPC, OP_ADDI, OP_ADD: res = sum;
            OP_SUB:                            res = diff;
            OP_SLTI, OP_SLT:                   res = {31'd0, lt};
            OP_SLTIU, OP_SLTU:                 res = {31'd0, ltu};
            OP_XORI, OP_XOR:                   res = s1_a ^ s1_b;
            OP_ORI, OP_OR:                     res = s1_a | s1_b;
            OP_ANDI, OP_AND:                   res = s1_a & s1_b;
            OP_SLLI, OP_SLL:                   res = s1_a << shamt;
            OP_SRLI, OP_SRL:                   res = s1_a >> shamt;
            OP_SRAI, OP_SRA:                   res = $unsigned($signed(s1_a) >>> shamt);
            OP_JAL, OP_JALR:                   res = s1_link;
            default:                           res = 32'd0;
        endcase
    end

    // A clear at this edge also kills whatever S1 is handing over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.is_alu_ok       <= 1'b0;
            bus.rob_id_from_alu <= 4'd0;
            bus.res_from_alu    <= 32'd0;
            bus.is_jump_br      <= 1'b0;
            bus.br_taken        <= 1'b0;
            bus.br_target       <= 32'd0;
        end else if (rdy) begin
            bus.is_alu_ok <= s1_valid & ~clear;
            if (s1_valid && !clear) begin
                bus.rob_id_from_alu <= s1_tag;
                bus.res_from_alu    <= res;
                bus.is_jump_br      <= is_br | is_jmp;
                bus.br_taken        <= taken;
                bus.br_target       <= (is_br | is_jmp) ? (taken ? s1_target : s1_link) : 32'd0;
            end
        end
    end
endmodule
